// File: rtl/addr_decode_pipe_pkg.sv
// addr_decode_pipe_pkg: shared config field encoding and sizing helpers for the address decoder
package addr_decode_pipe_pkg;
  typedef enum logic [1:0] {START = 2'd0, END = 2'd1, IDX = 2'd2, EN = 2'd3} cfg_field_e;
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int unsigned rule_width(int unsigned addr_w, int unsigned idx_w);
    return 1 + idx_w + 2 * addr_w;
  endfunction
endpackage

// File: rtl/addr_decode_pipe_match.sv
// addr_decode_pipe_match: combinational lookup of one address against the active rule table
module addr_decode_pipe_match
  import addr_decode_pipe_pkg::*;
#(
  parameter int unsigned NoRules   = 8,
  parameter int unsigned AddrWidth = 32,
  parameter bit          Napot     = 1'b0,
  parameter int unsigned IdxWidth  = 2,
  parameter int unsigned RuleWidth = rule_width(AddrWidth, IdxWidth)
) (
  input  logic [AddrWidth-1:0]         addr_i,
  input  logic [NoRules*RuleWidth-1:0] rules_i,
  input  logic                         en_default_idx_i,
  input  logic [IdxWidth-1:0]          default_idx_i,
  output logic [IdxWidth-1:0]          idx_o,
  output logic                         dec_valid_o,
  output logic                         dec_error_o
);
  typedef struct packed {
    logic                 en;
    logic [IdxWidth-1:0]  idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } rule_t;
  rule_t [NoRules-1:0] rules;
  logic [IdxWidth-1:0] hit_idx;
  logic hit;
  assign rules = rules_i;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int r = 0; r < NoRules; r++) begin
      if (rules[r].en && (Napot ? ((addr_i & rules[r].end_addr) == (rules[r].start_addr & rules[r].end_addr))
                                : (addr_i >= rules[r].start_addr && (addr_i < rules[r].end_addr || rules[r].end_addr == '0)))) begin
        hit = 1'b1;
        hit_idx = rules[r].idx;
      end
    end
  end
  assign idx_o = hit ? hit_idx : (en_default_idx_i ? default_idx_i : '0);
  assign dec_valid_o = hit;
  assign dec_error_o = !hit && !en_default_idx_i;
endmodule

// File: rtl/addr_decode_pipe.sv
// addr_decode_pipe: multi-channel programmable address decoder with shadow/active rule tables and error counters
module addr_decode_pipe
  import addr_decode_pipe_pkg::*;
#(
  parameter int unsigned NoIndices    = 4,
  parameter int unsigned NoRules      = 8,
  parameter int unsigned NoChannels   = 2,
  parameter int unsigned AddrWidth    = 32,
  parameter bit          Napot        = 1'b0,
  parameter int unsigned CntWidth     = 16,
  parameter int unsigned IdxWidth     = idx_width(NoIndices),
  parameter int unsigned RuleIdxWidth = idx_width(NoRules)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_valid_i,
  input  logic [RuleIdxWidth-1:0]        cfg_rule_i,
  input  logic [1:0]                     cfg_field_i,
  input  logic [AddrWidth-1:0]           cfg_wdata_i,
  input  logic                           cfg_commit_i,
  output logic                           cfg_err_o,
  input  logic                           en_default_idx_i,
  input  logic [IdxWidth-1:0]            default_idx_i,
  input  logic [NoChannels-1:0]          req_valid_i,
  output logic [NoChannels-1:0]          req_ready_o,
  input  logic [NoChannels*AddrWidth-1:0] req_addr_i,
  output logic [NoChannels-1:0]          rsp_valid_o,
  input  logic [NoChannels-1:0]          rsp_ready_i,
  output logic [NoChannels*IdxWidth-1:0] rsp_idx_o,
  output logic [NoChannels-1:0]          rsp_dec_valid_o,
  output logic [NoChannels-1:0]          rsp_dec_error_o,
  output logic [NoChannels*CntWidth-1:0] err_cnt_o,
  input  logic                           err_cnt_clr_i
);
  localparam int unsigned RuleWidth = rule_width(AddrWidth, IdxWidth);
  typedef struct packed {
    logic                 en;
    logic [IdxWidth-1:0]  idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } rule_t;
  rule_t [NoRules-1:0] sh_q, sh_d, act_q, act_d;
  logic cfg_err_q, cfg_err_d, cfg_ok;
  logic [NoChannels-1:0] vld_q, vld_d, dv_q, dv_d, de_q, de_d, acc, m_dv, m_de;
  logic [NoChannels-1:0][IdxWidth-1:0] idx_q, idx_d, m_idx;
  logic [NoChannels-1:0][CntWidth-1:0] cnt_q, cnt_d;
  assign cfg_ok = ({1'b0, cfg_rule_i} < (RuleIdxWidth+1)'(NoRules))
                  && (cfg_field_e'(cfg_field_i) != IDX || cfg_wdata_i < AddrWidth'(NoIndices));
  always_comb begin
    sh_d = sh_q;
    cfg_err_d = cfg_valid_i && !cfg_ok;
    if (cfg_valid_i && cfg_ok) begin
      case (cfg_field_e'(cfg_field_i))
        START:   sh_d[cfg_rule_i].start_addr = cfg_wdata_i;
        END:     sh_d[cfg_rule_i].end_addr = cfg_wdata_i;
        IDX:     sh_d[cfg_rule_i].idx = cfg_wdata_i[IdxWidth-1:0];
        default: sh_d[cfg_rule_i].en = cfg_wdata_i[0];
      endcase
    end
    act_d = cfg_commit_i ? sh_d : act_q;
  end
  for (genvar c = 0; c < NoChannels; c++) begin : g_ch
    addr_decode_pipe_match #(
      .NoRules  (NoRules),
      .AddrWidth(AddrWidth),
      .Napot    (Napot),
      .IdxWidth (IdxWidth)
    ) u_match (
      .addr_i          (req_addr_i[c*AddrWidth +: AddrWidth]),
      .rules_i         (act_q),
      .en_default_idx_i(en_default_idx_i),
      .default_idx_i   (default_idx_i),
      .idx_o           (m_idx[c]),
      .dec_valid_o     (m_dv[c]),
      .dec_error_o     (m_de[c])
    );
  end
  assign req_ready_o = ~vld_q | rsp_ready_i;
  assign acc = req_valid_i & req_ready_o;
  always_comb begin
    vld_d = acc | (vld_q & ~rsp_ready_i);
    idx_d = idx_q;
    dv_d = dv_q;
    de_d = de_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NoChannels; i++) begin
      if (acc[i]) begin
        idx_d[i] = m_idx[i];
        dv_d[i] = m_dv[i];
        de_d[i] = m_de[i];
      end
      cnt_d[i] = err_cnt_clr_i ? '0
               : (acc[i] && m_de[i] && cnt_q[i] != '1) ? cnt_q[i] + CntWidth'(1) : cnt_q[i];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= '0;
      act_q <= '0;
      cfg_err_q <= 1'b0;
      vld_q <= '0;
      idx_q <= '0;
      dv_q <= '0;
      de_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q <= sh_d;
      act_q <= act_d;
      cfg_err_q <= cfg_err_d;
      vld_q <= vld_d;
      idx_q <= idx_d;
      dv_q <= dv_d;
      de_q <= de_d;
      cnt_q <= cnt_d;
    end
  end
  assign cfg_err_o = cfg_err_q;
  assign rsp_valid_o = vld_q;
  assign rsp_idx_o = idx_q;
  assign rsp_dec_valid_o = dv_q;
  assign rsp_dec_error_o = de_q;
  assign err_cnt_o = cnt_q;
endmodule

// File: tb/tb_addr_decode_pipe.sv
// tb_addr_decode_pipe: scoreboard bench driving range and napot decoders with shared stimulus
module tb_addr_decode_pipe;
  localparam int NI = 4, NR = 6, NC = 2, AW = 32, CW = 4, IW = 2, RIW = 3;
  typedef struct {logic [IW-1:0] idx; bit dv; bit de;} res_t;
  typedef struct {res_t r; res_t n;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_commit = 1'b0, en_def = 1'b0, clr = 1'b0;
  logic [RIW-1:0] cfg_rule = '0;
  logic [1:0] cfg_field = '0;
  logic [AW-1:0] cfg_wdata = '0;
  logic [IW-1:0] def_idx = '0;
  logic [NC-1:0] req_valid = '0, rsp_ready = '1;
  logic [NC*AW-1:0] req_addr = '0;
  logic r_cfg_err, n_cfg_err;
  logic [NC-1:0] r_req_ready, n_req_ready, r_rsp_valid, n_rsp_valid, r_dv, n_dv, r_de, n_de;
  logic [NC*IW-1:0] r_idx, n_idx;
  logic [NC*CW-1:0] r_cnt, n_cnt;
  logic [AW-1:0] sh_s[NR], sh_e[NR], ac_s[NR], ac_e[NR];
  logic [IW-1:0] sh_i[NR], ac_i[NR];
  bit sh_en[NR], ac_en[NR];
  exp_t q[NC][$];
  bit mvld[NC];
  int cnt_r[NC], cnt_n[NC];
  bit err_exp;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  addr_decode_pipe #(.NoIndices(NI), .NoRules(NR), .NoChannels(NC), .AddrWidth(AW), .Napot(1'b0), .CntWidth(CW)) u_rng (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_rule_i(cfg_rule), .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata), .cfg_commit_i(cfg_commit), .cfg_err_o(r_cfg_err), .en_default_idx_i(en_def),
    .default_idx_i(def_idx), .req_valid_i(req_valid), .req_ready_o(r_req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(r_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_idx_o(r_idx), .rsp_dec_valid_o(r_dv),
    .rsp_dec_error_o(r_de), .err_cnt_o(r_cnt), .err_cnt_clr_i(clr));
  addr_decode_pipe #(.NoIndices(NI), .NoRules(NR), .NoChannels(NC), .AddrWidth(AW), .Napot(1'b1), .CntWidth(CW)) u_nap (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_rule_i(cfg_rule), .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata), .cfg_commit_i(cfg_commit), .cfg_err_o(n_cfg_err), .en_default_idx_i(en_def),
    .default_idx_i(def_idx), .req_valid_i(req_valid), .req_ready_o(n_req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(n_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_idx_o(n_idx), .rsp_dec_valid_o(n_dv),
    .rsp_dec_error_o(n_de), .err_cnt_o(n_cnt), .err_cnt_clr_i(clr));
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic res_t dec(logic [AW-1:0] a, bit nap);
    for (int r = NR - 1; r >= 0; r--) begin
      bit m;
      m = nap ? ((a & ac_e[r]) == (ac_s[r] & ac_e[r])) : (a >= ac_s[r] && (ac_e[r] == 0 || a < ac_e[r]));
      if (ac_en[r] && m) return '{ac_i[r], 1'b1, 1'b0};
    end
    return en_def ? '{def_idx, 1'b0, 1'b0} : '{2'd0, 1'b0, 1'b1};
  endfunction
  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      sh_s[r] = '0; sh_e[r] = '0; sh_i[r] = '0; sh_en[r] = 1'b0;
      ac_s[r] = '0; ac_e[r] = '0; ac_i[r] = '0; ac_en[r] = 1'b0;
    end
    for (int c = 0; c < NC; c++) begin
      q[c].delete();
      mvld[c] = 1'b0;
      cnt_r[c] = 0;
      cnt_n[c] = 0;
    end
    err_exp = 1'b0;
  endtask
  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      bit acc;
      exp_t e;
      acc = req_valid[c] && (!mvld[c] || rsp_ready[c]);
      e.r = dec(req_addr[c*AW +: AW], 1'b0);
      e.n = dec(req_addr[c*AW +: AW], 1'b1);
      if (acc) q[c].push_back(e);
      if (clr) begin
        cnt_r[c] = 0;
        cnt_n[c] = 0;
      end else if (acc) begin
        if (e.r.de && cnt_r[c] < 2**CW - 1) cnt_r[c]++;
        if (e.n.de && cnt_n[c] < 2**CW - 1) cnt_n[c]++;
      end
      mvld[c] = acc || (mvld[c] && !rsp_ready[c]);
    end
    err_exp = cfg_valid && (cfg_rule >= NR || (cfg_field == 2 && cfg_wdata >= NI));
    if (cfg_valid && !err_exp)
      case (cfg_field)
        2'd0: sh_s[cfg_rule] = cfg_wdata;
        2'd1: sh_e[cfg_rule] = cfg_wdata;
        2'd2: sh_i[cfg_rule] = cfg_wdata[IW-1:0];
        default: sh_en[cfg_rule] = cfg_wdata[0];
      endcase
    if (cfg_commit) begin
      ac_s = sh_s; ac_e = sh_e; ac_i = sh_i; ac_en = sh_en;
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        chk("req_ready_r", r_req_ready[c], !mvld[c] || rsp_ready[c]);
        chk("req_ready_n", n_req_ready[c], !mvld[c] || rsp_ready[c]);
        chk("err_cnt_r", r_cnt[c*CW +: CW], cnt_r[c]);
        chk("err_cnt_n", n_cnt[c*CW +: CW], cnt_n[c]);
      end
      chk("cfg_err_r", r_cfg_err, err_exp);
      chk("cfg_err_n", n_cfg_err, err_exp);
    end
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst)
        for (int c = 0; c < NC; c++) begin
          if (r_rsp_valid[c] || n_rsp_valid[c] || q[c].size() != 0) begin
            if (q[c].size() == 0) chk("rsp_unexpected", r_rsp_valid[c] | n_rsp_valid[c], 0);
            else begin
              e = q[c][0];
              chk("rsp_valid_r", r_rsp_valid[c], 1);
              chk("rsp_valid_n", n_rsp_valid[c], 1);
              chk("rsp_idx_r", r_idx[c*IW +: IW], e.r.idx);
              chk("rsp_dv_r", r_dv[c], e.r.dv);
              chk("rsp_de_r", r_de[c], e.r.de);
              chk("rsp_idx_n", n_idx[c*IW +: IW], e.n.idx);
              chk("rsp_dv_n", n_dv[c], e.n.dv);
              chk("rsp_de_n", n_de[c], e.n.de);
              if (rsp_ready[c]) void'(q[c].pop_front());
            end
          end
        end
    end
  end
  task automatic wr(int rule, int field, logic [AW-1:0] data);
    cfg_valid = 1'b1; cfg_rule = RIW'(rule); cfg_field = 2'(field); cfg_wdata = data;
    cyc();
    cfg_valid = 1'b0;
  endtask
  task automatic do_commit();
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
  endtask
  task automatic lookup(int c, logic [AW-1:0] a);
    req_valid[c] = 1'b1;
    req_addr[c*AW +: AW] = a;
    cyc();
    req_valid[c] = 1'b0;
  endtask
  task automatic lit(string name, int c, bit nap, logic [IW-1:0] idx, bit dv, bit de);
    chk({name, "_vld"}, nap ? n_rsp_valid[c] : r_rsp_valid[c], 1);
    chk({name, "_idx"}, nap ? n_idx[c*IW +: IW] : r_idx[c*IW +: IW], idx);
    chk({name, "_dv"}, nap ? n_dv[c] : r_dv[c], dv);
    chk({name, "_de"}, nap ? n_de[c] : r_de[c], de);
  endtask
  initial begin
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_valid", {r_rsp_valid, n_rsp_valid}, 0);
    chk("rst_idx", {r_idx, n_idx}, 0);
    chk("rst_dv_de", {r_dv, n_dv, r_de, n_de}, 0);
    chk("rst_cnt", {r_cnt, n_cnt}, 0);
    chk("rst_cfg_err", {r_cfg_err, n_cfg_err}, 0);
    wr(0, 0, 'h1000); wr(0, 1, 'h2000); wr(0, 2, 1); wr(0, 3, 1); do_commit();
    lookup(0, 'h1800); lit("rule0", 0, 0, 1, 1, 0);
    wr(3, 0, 'h1800); wr(3, 1, 'h1900); wr(3, 2, 2); wr(3, 3, 1);
    lookup(0, 'h1880); lit("pre_commit", 0, 0, 1, 1, 0);
    cfg_commit = 1'b1;
    lookup(0, 'h1880);
    cfg_commit = 1'b0;
    lit("commit_cycle", 0, 0, 1, 1, 0);
    lookup(0, 'h1880); lit("post_commit", 0, 0, 2, 1, 0);
    lookup(0, 'h1900); lit("end_excl", 0, 0, 1, 1, 0);
    lookup(0, 'h5000); lit("miss", 0, 0, 0, 0, 1);
    chk("cnt_miss", r_cnt[CW-1:0], 1);
    en_def = 1'b1; def_idx = 2'd3;
    lookup(0, 'h5000); lit("default", 0, 0, 3, 0, 0);
    chk("cnt_default", r_cnt[CW-1:0], 1);
    en_def = 1'b0;
    rsp_ready = 2'b01; req_valid = 2'b11; req_addr = {32'h1880, 32'h1800};
    repeat (5) cyc();
    chk("stall_ready", r_req_ready[1], 0);
    rsp_ready = 2'b11; req_valid = 2'b00;
    cyc();
    wr(0, 2, NI); chk("cfg_err_idx", r_cfg_err, 1);
    wr(NR, 0, 'hdead); chk("cfg_err_rule", r_cfg_err, 1);
    do_commit();
    lookup(0, 'h1000); lit("tbl_unchanged", 0, 0, 1, 1, 0);
    wr(0, 3, 0); wr(3, 3, 0);
    wr(5, 0, 'h4000); wr(5, 1, 'hFFFFF000); wr(5, 2, 2); wr(5, 3, 1); do_commit();
    lookup(0, 'h4ABC); lit("napot_hit", 0, 1, 2, 1, 0);
    lookup(0, 'h5000); lit("napot_miss", 0, 1, 0, 0, 1);
    repeat (20) lookup(0, 'hFFFFF800);
    chk("sat_r", r_cnt[CW-1:0], 2**CW - 1);
    chk("sat_n", n_cnt[CW-1:0], 2**CW - 1);
    clr = 1'b1;
    lookup(0, 'hFFFFF800);
    clr = 1'b0;
    chk("clr_r", r_cnt[CW-1:0], 0);
    chk("clr_n", n_cnt[CW-1:0], 0);
    repeat (3000) begin
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_rule = RIW'($urandom_range(0, 7));
      cfg_field = 2'($urandom_range(0, 3));
      cfg_wdata = (cfg_field == 2) ? $urandom_range(0, 5) : (cfg_field == 3) ? $urandom_range(0, 1)
                : ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 'hFFFF);
      cfg_commit = ($urandom_range(0, 9) == 0);
      en_def = 1'($urandom_range(0, 1));
      def_idx = IW'($urandom_range(0, 3));
      clr = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < NC; c++) begin
        req_valid[c] = 1'($urandom_range(0, 1));
        rsp_ready[c] = ($urandom_range(0, 3) != 0);
        req_addr[c*AW +: AW] = $urandom_range(0, 'hFFFF);
      end
      cyc();
    end
    cfg_valid = 1'b0; cfg_commit = 1'b0; clr = 1'b0; en_def = 1'b0; rsp_ready = 2'b11;
    req_valid = 2'b11;
    cyc();
    req_valid = 2'b00;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_drop", {r_rsp_valid, n_rsp_valid}, 0);
    lookup(1, 'h1000); lit("rst_table", 1, 0, 0, 0, 1);
    repeat (3) cyc();
    for (int c = 0; c < NC; c++) chk("drain", q[c].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
